// File: rtl/pio_event_scheduler.sv
// Debounced key/switch change-event queue behind the hello-core PIO ports.
// Optional TSTAMP_EN macro adds a 22-bit tick timestamp to each event.
module pio_event_scheduler #(
  parameter int KEY_W        = 4,
  parameter int SW_W         = 18,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int FIFO_DEPTH   = 8,
  parameter int TS_DIV       = 50
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [KEY_W-1:0]  keys_in,
  input  logic [SW_W-1:0]   switches_in,
  input  logic [31:0]       host_ctrl,
  output logic [31:0]       event_word,
  output logic [KEY_W-1:0]  keys_db,
  output logic [SW_W-1:0]   switches_db,
  output logic [6:0]        fifo_level
);

  localparam int N  = KEY_W + SW_W;
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [N-1:0]  raw;
  logic [N-1:0]  sync1;
  logic [N-1:0]  sync2;
  logic [N-1:0]  stable;
  logic [N-1:0]  strobe;
  logic [N-1:0]  pending;
  logic [N-1:0]  deq_mask;
  logic [CW-1:0] cnt [N];

  logic          ack_seen;
  logic          clr_q;
  logic          ovf;
  logic          coalesce;
  logic          clr_rise;
  logic          toggle;
  logic          enable;

  logic          any;
  logic [4:0]    sel_idx;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  logic [29:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [6:0]    count;
  logic [29:0]   wr_entry;
  logic [1:0]    src;
  logic [4:0]    idx;
  logic [21:0]   ts_now;
  logic [31:0]   head_q;
  logic          unused_host;

  assign raw         = {switches_in, keys_in};
  assign unused_host = ^host_ctrl[31:3];
  assign enable      = host_ctrl[2];
  assign toggle      = host_ctrl[0] ^ ack_seen;
  assign clr_rise    = host_ctrl[1] & ~clr_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // strobe fires in the cycle the counter would hit its terminal count
  always_comb begin
    strobe = '0;
    for (int i = 0; i < N; i++) begin
      strobe[i] = (sync2[i] != stable[i])
                  && (cnt[i] == CW'(DEBOUNCE_CYC - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (strobe[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    any     = 1'b0;
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) begin
        any     = 1'b1;
        sel_idx = 5'(i);
      end
    end
  end

  assign empty = (count == 7'd0);
  assign full  = (count == 7'(FIFO_DEPTH));
  assign pop   = toggle & ~empty;
  assign push  = enable & any & (~full | pop);

  always_comb begin
    deq_mask = '0;
    if (push) deq_mask[sel_idx] = 1'b1;
  end

  // a bit already being dequeued this cycle is not a coalesce
  assign coalesce = |(strobe & pending & ~deq_mask);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending  <= '0;
      ovf      <= 1'b0;
      clr_q    <= 1'b0;
      ack_seen <= 1'b0;
    end else begin
      pending  <= (pending & ~deq_mask) | strobe;
      clr_q    <= host_ctrl[1];
      ack_seen <= host_ctrl[0];
      if (coalesce)      ovf <= 1'b1;
      else if (clr_rise) ovf <= 1'b0;
    end
  end

`ifdef TSTAMP_EN
  localparam int DW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [21:0]   ts_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      ts_cnt  <= '0;
    end else if (div_cnt == DW'(TS_DIV - 1)) begin
      div_cnt <= '0;
      ts_cnt  <= ts_cnt + 22'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign ts_now = ts_cnt;
`else
  localparam int unused_ts_div = TS_DIV;

  assign ts_now = '0;
`endif

  assign src = (sel_idx < 5'(KEY_W)) ? 2'b00 : 2'b01;
  assign idx = (sel_idx < 5'(KEY_W)) ? sel_idx : sel_idx - 5'(KEY_W);
  assign wr_entry = {src, idx, stable[sel_idx], ts_now};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 7'd1;
        2'b01:   count <= count - 7'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q <= '0;
    end else if (!empty) begin
      head_q <= {1'b1, ovf, mem[rd_ptr]};
    end else begin
      head_q <= {1'b0, ovf, 30'd0};
    end
  end

  assign event_word  = head_q;
  assign keys_db     = stable[KEY_W-1:0];
  assign switches_db = stable[N-1:KEY_W];
  assign fifo_level  = count;

endmodule

// File: tb/tb_pio_event_scheduler.sv
// Scoreboard bench for pio_event_scheduler (DEBOUNCE_CYC=4, FIFO_DEPTH=4, TS_DIV=2).
module tb_pio_event_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  keys_in;
  logic [17:0] switches_in;
  logic        ack;
  logic        clr;
  logic        en;
  logic [31:0] host_ctrl;
  logic [31:0] event_word;
  logic [3:0]  keys_db;
  logic [17:0] switches_db;
  logic [6:0]  fifo_level;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sbq[$];
  logic [31:0] exp_w;

`ifdef TSTAMP_EN
  localparam logic [31:0] MASK = 32'hFFC0_0000;
`else
  localparam logic [31:0] MASK = 32'hFFFF_FFFF;
`endif

  assign host_ctrl = {29'd0, en, clr, ack};

  always #5 clk = ~clk;

  pio_event_scheduler #(
    .KEY_W(4), .SW_W(18), .DEBOUNCE_CYC(4),
    .FIFO_DEPTH(4), .TS_DIV(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .keys_in(keys_in),
    .switches_in(switches_in),
    .host_ctrl(host_ctrl),
    .event_word(event_word),
    .keys_db(keys_db),
    .switches_db(switches_db),
    .fifo_level(fifo_level)
  );

  function automatic logic [31:0] ev(int src, int idx, bit lvl);
    return {1'b1, 1'b0, src[1:0], idx[4:0], lvl, 22'd0};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    keys_in = '0;
    switches_in = '0;
    ack = 1'b0;
    clr = 1'b0;
    en = 1'b1;
    tick(2);
    reset_n = 1'b1;
    sbq.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    keys_in = 4'hF;
    switches_in = '1;
    ack = 1'b0;
    clr = 1'b0;
    en = 1'b0;
    tick(3);
    checks++;
    if (event_word !== 32'd0) begin
      failures++;
      $display("FAIL reset_event_word got=%h exp=0", event_word);
    end
    checks++;
    if (fifo_level !== 7'd0) begin
      failures++;
      $display("FAIL reset_fifo_level got=%0d exp=0", fifo_level);
    end
    checks++;
    if (keys_db !== 4'd0 || switches_db !== 18'd0) begin
      failures++;
      $display("FAIL reset_db got=%h/%h exp=0", keys_db, switches_db);
    end
    keys_in = '0;
    switches_in = '0;
  endtask

  task automatic test_key_event();
    do_reset();
    keys_in[2] = 1'b1;
    sbq.push_back(ev(0, 2, 1'b1));
    tick(5);
    checks++;
    if (keys_db !== 4'd0) begin
      failures++;
      $display("FAIL key_db_early got=%h exp=0", keys_db);
    end
    tick(1);
    checks++;
    if (keys_db !== 4'b0100) begin
      failures++;
      $display("FAIL key_db_6clk got=%h exp=4", keys_db);
    end
    tick(1);
    checks++;
    if (fifo_level !== 7'd1 || event_word !== 32'd0) begin
      failures++;
      $display("FAIL key_enq got lvl=%0d word=%h exp lvl=1 word=0",
               fifo_level, event_word);
    end
    tick(1);
    exp_w = sbq.pop_front();
    checks++;
    if ((event_word & MASK) !== exp_w) begin
      failures++;
      $display("FAIL key_head got=%h exp=%h", event_word & MASK, exp_w);
    end
    ack = ~ack;
    tick(1);
    checks++;
    if (fifo_level !== 7'd0) begin
      failures++;
      $display("FAIL key_pop_lvl got=%0d exp=0", fifo_level);
    end
    tick(1);
    checks++;
    if (event_word !== 32'd0) begin
      failures++;
      $display("FAIL key_pop_word got=%h exp=0", event_word);
    end
  endtask

  task automatic test_glitch();
    logic [3:0] seen_db;
    logic [6:0] seen_lvl;
    do_reset();
    seen_db = '0;
    seen_lvl = '0;
    keys_in[1] = 1'b1;
    tick(3);
    keys_in[1] = 1'b0;
    repeat (12) begin
      tick(1);
      seen_db = seen_db | keys_db;
      seen_lvl = seen_lvl | fifo_level;
    end
    checks++;
    if (seen_db !== 4'd0) begin
      failures++;
      $display("FAIL glitch_db got=%h exp=0", seen_db);
    end
    checks++;
    if (seen_lvl !== 7'd0) begin
      failures++;
      $display("FAIL glitch_lvl got=%0d exp=0", seen_lvl);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    switches_in = 18'h002A9;
    sbq.push_back(ev(1, 0, 1'b1));
    sbq.push_back(ev(1, 3, 1'b1));
    sbq.push_back(ev(1, 5, 1'b1));
    sbq.push_back(ev(1, 7, 1'b1));
    sbq.push_back(ev(1, 9, 1'b1));
    tick(12);
    checks++;
    if (fifo_level !== 7'd4) begin
      failures++;
      $display("FAIL full_lvl got=%0d exp=4", fifo_level);
    end
    exp_w = sbq.pop_front();
    checks++;
    if ((event_word & MASK) !== exp_w) begin
      failures++;
      $display("FAIL full_head0 got=%h exp=%h", event_word & MASK, exp_w);
    end
    ack = ~ack;
    tick(1);
    checks++;
    if (fifo_level !== 7'd4) begin
      failures++;
      $display("FAIL full_push_pop got=%0d exp=4", fifo_level);
    end
    tick(1);
    for (int k = 0; k < 4; k++) begin
      exp_w = sbq.pop_front();
      checks++;
      if ((event_word & MASK) !== exp_w) begin
        failures++;
        $display("FAIL full_drain%0d got=%h exp=%h",
                 k, event_word & MASK, exp_w);
      end
      ack = ~ack;
      tick(2);
    end
    checks++;
    if (fifo_level !== 7'd0 || event_word !== 32'd0) begin
      failures++;
      $display("FAIL full_empty got lvl=%0d word=%h exp 0/0",
               fifo_level, event_word);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    switches_in = 18'h002A8;
    sbq.push_back(ev(1, 3, 1'b1));
    sbq.push_back(ev(1, 5, 1'b1));
    sbq.push_back(ev(1, 7, 1'b1));
    sbq.push_back(ev(1, 9, 1'b1));
    tick(12);
    switches_in[0] = 1'b1;
    tick(10);
    checks++;
    if (event_word[30] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_first_edge got=%b exp=0", event_word[30]);
    end
    switches_in[0] = 1'b0;
    tick(10);
    checks++;
    if (event_word[30] !== 1'b1 || fifo_level !== 7'd4) begin
      failures++;
      $display("FAIL ovf_set got ovf=%b lvl=%0d exp 1/4",
               event_word[30], fifo_level);
    end
    clr = 1'b1;
    tick(2);
    checks++;
    if (event_word[30] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", event_word[30]);
    end
    sbq.push_back(ev(1, 0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      exp_w = sbq.pop_front();
      checks++;
      if ((event_word & MASK) !== exp_w) begin
        failures++;
        $display("FAIL ovf_drain%0d got=%h exp=%h",
                 k, event_word & MASK, exp_w);
      end
      ack = ~ack;
      tick(2);
    end
    checks++;
    if (fifo_level !== 7'd0) begin
      failures++;
      $display("FAIL ovf_empty got=%0d exp=0", fifo_level);
    end
    clr = 1'b0;
  endtask

  task automatic test_empty_ack();
    int n;
    do_reset();
    tick(2);
    ack = ~ack;
    tick(3);
    checks++;
    if (fifo_level !== 7'd0 || event_word !== 32'd0) begin
      failures++;
      $display("FAIL empty_ack got lvl=%0d word=%h exp 0/0",
               fifo_level, event_word);
    end
    keys_in[0] = 1'b1;
    sbq.push_back(ev(0, 0, 1'b1));
    n = 0;
    while (event_word[31] !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    exp_w = sbq.pop_front();
    checks++;
    if ((event_word & MASK) !== exp_w) begin
      failures++;
      $display("FAIL empty_then_key got=%h exp=%h", event_word & MASK, exp_w);
    end
    tick(3);
    checks++;
    if (event_word[31] !== 1'b1 || fifo_level !== 7'd1) begin
      failures++;
      $display("FAIL no_silent_pop got v=%b lvl=%0d exp 1/1",
               event_word[31], fifo_level);
    end
    ack = ~ack;
    tick(2);
    checks++;
    if (fifo_level !== 7'd0) begin
      failures++;
      $display("FAIL empty_final got=%0d exp=0", fifo_level);
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0;
    keys_in[3] = 1'b1;
    sbq.push_back(ev(0, 3, 1'b1));
    tick(15);
    checks++;
    if (fifo_level !== 7'd0 || keys_db !== 4'b1000) begin
      failures++;
      $display("FAIL en_hold got lvl=%0d db=%h exp 0/8", fifo_level, keys_db);
    end
    en = 1'b1;
    tick(1);
    checks++;
    if (fifo_level !== 7'd1) begin
      failures++;
      $display("FAIL en_enq got=%0d exp=1", fifo_level);
    end
    tick(1);
    exp_w = sbq.pop_front();
    checks++;
    if ((event_word & MASK) !== exp_w) begin
      failures++;
      $display("FAIL en_head got=%h exp=%h", event_word & MASK, exp_w);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    switches_in = 18'h3;
    tick(12);
    checks++;
    if (fifo_level !== 7'd2) begin
      failures++;
      $display("FAIL mid_fill got=%0d exp=2", fifo_level);
    end
    reset_n = 1'b0;
    tick(1);
    checks++;
    if (event_word !== 32'd0 || fifo_level !== 7'd0 || switches_db !== 18'd0) begin
      failures++;
      $display("FAIL mid_reset got word=%h lvl=%0d db=%h exp 0",
               event_word, fifo_level, switches_db);
    end
    switches_in = '0;
    reset_n = 1'b1;
    tick(2);
  endtask

`ifdef TSTAMP_EN
  task automatic test_tstamp();
    logic [31:0] w1;
    logic [31:0] w2;
    logic [21:0] d;
    do_reset();
    keys_in[0] = 1'b1;
    tick(20);
    keys_in[1] = 1'b1;
    tick(20);
    w1 = event_word;
    ack = ~ack;
    tick(2);
    w2 = event_word;
    d = w2[21:0] - w1[21:0];
    checks++;
    if ((w1 & MASK) !== ev(0, 0, 1'b1) || (w2 & MASK) !== ev(0, 1, 1'b1)) begin
      failures++;
      $display("FAIL ts_events got=%h/%h", w1, w2);
    end
    checks++;
    if (d !== 22'd10) begin
      failures++;
      $display("FAIL ts_delta got=%0d exp=10", d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_key_event();
    test_glitch();
    test_fifo_full();
    test_overflow();
    test_empty_ack();
    test_enable();
    test_reset_mid();
`ifdef TSTAMP_EN
    test_tstamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
